// File: rtl/fldexp_pipe.sv
// fldexp_pipe -- two-stage valid/ready pipeline computing y = x * 2^k for an
// IEEE-754 single-precision operand x and a signed integer exponent k.
// The scaling is exact: only the biased exponent changes. Results that
// would become denormal are flushed to signed zero (unf), and results that
// would leave the finite range saturate to signed infinity (ovf). Zero or
// denormal inputs give signed zero. Inf/NaN inputs pass through unchanged.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream presents x,k
//   in_ready   block accepts x,k this cycle
//   x          IEEE-754 single operand
//   k          signed power-of-two exponent (KW bits, two's complement)
//   out_valid  y, ovf, unf are valid
//   out_ready  downstream accepts the result
//   y          IEEE-754 single result
//   ovf        result saturated to infinity
//   unf        a normal input was flushed to zero
module fldexp_pipe #(
   parameter int KW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   x,
   input  logic [KW-1:0] k,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   y,
   output logic          ovf,
   output logic          unf
);

   // Width of the scaled exponent: holds 0..255 plus any KW-bit k without wrap.
   localparam int TW = KW + 2;
   localparam logic signed [TW-1:0] T_ZERO = '0;
   localparam logic signed [TW-1:0] T_SAT  = TW'(255);

   // Exponent rewrite with flush-to-zero and saturate-to-infinity.
   // Returns {ovf, unf, y}; branch order sets the precedence.
   function automatic logic [33:0] scale_exp(
      input logic                 s,
      input logic [7:0]           e,
      input logic [22:0]          m,
      input logic signed [TW-1:0] t
   );
      logic [33:0] r;
      r = {2'b00, s, 31'b0};
      if (e == 8'd0)
         r = {2'b00, s, 31'b0};
      else if (e == 8'hFF)
         r = {2'b00, s, e, m};
      else if (t <= T_ZERO)
         r = {2'b01, s, 31'b0};
      else if (t >= T_SAT)
         r = {2'b10, s, 8'hFF, 23'b0};
      else
         r = {2'b00, s, t[7:0], m};
      return r;
   endfunction

   logic                 vld_p1;
   logic                 s_p1;
   logic [7:0]           e_p1;
   logic [22:0]          m_p1;
   logic signed [TW-1:0] t_p1;

   logic                 vld_p2;
   logic [31:0]          y_p2;
   logic                 ovf_p2;
   logic                 unf_p2;

   logic                 load_p1;
   logic                 load_p2;
   logic signed [TW-1:0] t_in;
   logic [33:0]          cls_p1;

   // A stage advances when it is empty or the stage after it advances.
   always_comb begin
      load_p2  = !vld_p2 || out_ready;
      load_p1  = !vld_p1 || load_p2;
      in_ready = load_p1;
   end

   always_comb begin
      t_in = $signed({{(KW-6){1'b0}}, x[30:23]}) + $signed({{2{k[KW-1]}}, k});
   end

   // ---- stage 1: split operand, form scaled exponent ----
   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (load_p1)
         vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (load_p1 && in_valid) begin
         s_p1 <= x[31];
         e_p1 <= x[30:23];
         m_p1 <= x[22:0];
         t_p1 <= t_in;
      end
   end

   always_comb begin
      cls_p1 = scale_exp(s_p1, e_p1, m_p1, t_p1);
   end

   // ---- stage 2: classify and register the result ----
   // The result registers are cleared by reset so y reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         y_p2   <= 32'h0;
         ovf_p2 <= 1'b0;
         unf_p2 <= 1'b0;
      end else if (load_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            ovf_p2 <= cls_p1[33];
            unf_p2 <= cls_p1[32];
            y_p2   <= cls_p1[31:0];
         end
      end
   end

   always_comb begin
      out_valid = vld_p2;
      y         = y_p2;
      ovf       = ovf_p2;
      unf       = unf_p2;
   end

endmodule

// File: tb/tb_fldexp_pipe.sv
module tb_fldexp_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic [8:0]  k;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        ovf;
   logic        unf;

   int nchk  = 0;
   int nfail = 0;

   fldexp_pipe #(.KW(9)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .k(k),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [8:0]  k;
      logic [31:0] y;
      logic        ovf;
      logic        unf;
   } vec_t;

   vec_t tbl[14];

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      logic        unf;
   } res_t;

   res_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: value-level x * 2^k with the flush/saturate rules.
   function automatic res_t model(input logic [31:0] xx, input logic [8:0] kk);
      res_t r;
      int e;
      int kv;
      int t;
      logic [7:0] tb8;
      e  = int'(xx[30:23]);
      kv = $signed(kk);
      t  = e + kv;
      tb8 = 8'(t);
      r.ovf = 1'b0;
      r.unf = 1'b0;
      if (e == 0)            r.y = {xx[31], 31'b0};
      else if (e == 255)     r.y = xx;
      else if (t <= 0) begin r.y = {xx[31], 31'b0}; r.unf = 1'b1; end
      else if (t >= 255) begin r.y = {xx[31], 8'hFF, 23'b0}; r.ovf = 1'b1; end
      else                   r.y = {xx[31], tb8, xx[22:0]};
      return r;
   endfunction

   // Team fhalf behaviour for normal inputs: halve, flushing the smallest exponent.
   function automatic logic [31:0] fhalf(input logic [31:0] xx);
      if (xx[30:23] > 8'd1) return {xx[31], xx[30:23] - 8'd1, xx[22:0]};
      return {xx[31], 31'b0};
   endfunction

   // Single transfer on an empty pipe with out_ready high; checks the
   // 2-cycle latency and returns the result. Called right after a posedge.
   task automatic xfer(input logic [31:0] xi, input logic [8:0] ki, output res_t r);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x = xi;
      k = ki;
      #1;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("latency_not_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("latency_valid", 32'(out_valid), 32'd1);
      r.y = y; r.ovf = ovf; r.unf = unf;
   endtask

   logic [31:0] a_vals[4];
   res_t        r;
   res_t        m;
   int          idx;
   int          sent;
   int          got;
   int          guard;

   initial begin
      tbl[0]  = '{32'h3F800000, 9'h001, 32'h40000000, 1'b0, 1'b0};
      tbl[1]  = '{32'h40000000, 9'h1FF, 32'h3F800000, 1'b0, 1'b0};
      tbl[2]  = '{32'hC0490FDB, 9'h1FF, 32'hBFC90FDB, 1'b0, 1'b0};
      tbl[3]  = '{32'h7F000000, 9'h001, 32'h7F800000, 1'b1, 1'b0};
      tbl[4]  = '{32'h80800000, 9'h1FF, 32'h80000000, 1'b0, 1'b1};
      tbl[5]  = '{32'h00400000, 9'h005, 32'h00000000, 1'b0, 1'b0};
      tbl[6]  = '{32'h7FC00000, 9'h1FD, 32'h7FC00000, 1'b0, 1'b0};
      tbl[7]  = '{32'hFF800000, 9'h19C, 32'hFF800000, 1'b0, 1'b0};
      tbl[8]  = '{32'h80000000, 9'h032, 32'h80000000, 1'b0, 1'b0};
      tbl[9]  = '{32'h3F800000, 9'h181, 32'h00000000, 1'b0, 1'b1};
      tbl[10] = '{32'h3F800000, 9'h182, 32'h00800000, 1'b0, 1'b0};
      tbl[11] = '{32'h3F800000, 9'h07F, 32'h7F000000, 1'b0, 1'b0};
      tbl[12] = '{32'h3F800000, 9'h080, 32'h7F800000, 1'b1, 1'b0};
      tbl[13] = '{32'hBF800000, 9'h100, 32'h80000000, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; k = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", y, 32'h0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_unf", 32'(unf), 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < 14; i++) begin
         xfer(tbl[i].x, tbl[i].k, r);
         check($sformatf("vec%0d_y", i), r.y, tbl[i].y);
         check($sformatf("vec%0d_ovf", i), 32'(r.ovf), 32'(tbl[i].ovf));
         check($sformatf("vec%0d_unf", i), 32'(r.unf), 32'(tbl[i].unf));
      end

      // k = -1 against fhalf over every normal exponent
      for (int e = 1; e <= 254; e++) begin
         logic [31:0] xs;
         xs = {1'($urandom), 8'(e), 23'($urandom)};
         xfer(xs, 9'h1FF, r);
         check($sformatf("fhalf_e%0d", e), r.y, fhalf(xs));
      end
      @(posedge clk); #1;

      // Stall then release: two accepted, then four results in order
      a_vals[0] = 32'h40000000; a_vals[1] = 32'h40400000;
      a_vals[2] = 32'h40800000; a_vals[3] = 32'h40A00000;
      out_ready = 1'b0; k = 9'h000; idx = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; x = a_vals[idx];
         #1;
         if (in_ready) idx++;
         @(posedge clk); #1;
      end
      check("stall_accepted", 32'(idx), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_valid = (idx < 4);
         x = a_vals[idx < 4 ? idx : 3];
         #1;
         check($sformatf("drain_valid%0d", j), 32'(out_valid), 32'd1);
         check($sformatf("drain_y%0d", j), y, a_vals[j]);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1;
      check("drain_empty", 32'(out_valid), 32'd0);
      check("drain_in_ready", 32'(in_ready), 32'd1);
      check("drain_all_in", 32'(idx), 32'd4);

      // Reset with two operands in flight, in_valid held during reset
      out_ready = 1'b0; in_valid = 1'b1; x = 32'h3F800000; k = 9'h001;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; x = 32'h40400000;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_y", y, 32'h0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (out_valid) got++;
      end
      check("midrst_no_stale", 32'(got), 32'd0);
      xfer(32'h3F800000, 9'h002, r);
      check("midrst_recover_y", r.y, 32'h40800000);
      @(posedge clk); #1;

      // Random traffic against the reference model
      sent = 0; got = 0;
      for (int c = 0; c < 30000 && sent < 6000; c++) begin
         out_ready = ($urandom_range(0, 9) < 6);
         in_valid  = ($urandom_range(0, 9) < 7);
         x = $urandom;
         if ($urandom_range(0, 1) == 1) k = 9'($urandom);
         else k = 9'($signed($urandom_range(0, 40)) - 20);
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(x, k));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_extra_result", 32'(out_valid), 32'd0);
            end else begin
               m = exp_q.pop_front();
               check("rand_y", y, m.y);
               check("rand_flags", {30'b0, ovf, unf}, {30'b0, m.ovf, m.unf});
               got++;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 1000) begin
         #1;
         if (out_valid) begin
            m = exp_q.pop_front();
            check("rand_y", y, m.y);
            check("rand_flags", {30'b0, ovf, unf}, {30'b0, m.ovf, m.unf});
            got++;
         end
         @(posedge clk); #1;
         guard++;
      end
      check("rand_count", 32'(got), 32'(sent));
      check("rand_tail_empty", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
